// File: rtl/audio_pkg.sv
// Shared definitions for the audio path: tone burst FSM states and the
// default sizing constants used by the tone generator.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } tone_state_t;

  // 1 ms duration tick at a 48 MHz system clock.
  localparam int TICK_DIV_1MS = 48000;
  localparam int DIV_W_DEF    = 16;

endpackage

// File: rtl/tone_div.sv
// Half-period divider for the tone generator: counts clk cycles up to the
// programmed half period and toggles the square-wave phase on each wrap.
module tone_div
  import audio_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] half_period,
  output logic             phase
);

  logic [DIV_W-1:0] cnt;

  // A zero half period freezes the divider so H-1 never underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (en && (half_period != '0)) begin
      if (cnt == half_period - DIV_W'(1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/tone_burst_gen.sv
// Programmable speaker burst generator: differential square wave with
// configurable tone frequency, on/off durations and beep count.
module tone_burst_gen
  import audio_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int TICK_DIV = TICK_DIV_1MS,
  parameter int DUR_W    = 12,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] half_period,
  input  logic [DUR_W-1:0] on_ticks,
  input  logic [DUR_W-1:0] off_ticks,
  input  logic [CNT_W-1:0] beeps,
  output logic             spk_p,
  output logic             spk_n,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  tone_state_t      state_q;
  tone_state_t      state_d;
  logic [DIV_W-1:0] h_q;
  logic [DIV_W-1:0] h_next;
  logic [DUR_W-1:0] on_q;
  logic [DUR_W-1:0] off_q;
  logic [DUR_W-1:0] dur_q;
  logic [CNT_W-1:0] beep_q;
  logic [PW-1:0]    presc_q;
  logic             tick;
  logic             on_expire;
  logic             off_expire;
  logic             last_beep;
  logic             accept;
  logic             reload;
  logic             div_clr;
  logic             div_en;
  logic             phase;
  logic             busy_d;
  logic             done_d;
  logic             sound_d;
  logic             sound_q;

  assign tick       = (presc_q == PRESC_MAX);
  assign on_expire  = tick && (dur_q == on_q - DUR_W'(1));
  assign off_expire = tick && (dur_q == off_q - DUR_W'(1));
  assign last_beep  = (beep_q <= CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stop overrides every other transition, including a same-cycle start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = TONE;
      TONE: begin
        if (on_expire) begin
          if (last_beep)            state_d = IDLE;
          else if (off_q != '0)     state_d = GAP;
          else                      state_d = TONE;
        end
      end
      GAP:  if (off_expire) state_d = TONE;
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  // reload also covers TONE->TONE, which is a fresh beep with no state change.
  always_comb begin
    accept  = (state_q == IDLE) && start && !stop;
    reload  = (state_d != state_q) || ((state_q == TONE) && on_expire);
    div_clr = (state_d == TONE) && reload;
    div_en  = (state_q == TONE);
    h_next  = accept ? half_period : h_q;
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == TONE) && on_expire && last_beep && !stop;
    sound_d = (state_d == TONE) && (h_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      on_q  <= '0;
      off_q <= '0;
    end else if (accept) begin
      h_q   <= half_period;
      on_q  <= (on_ticks == '0) ? DUR_W'(1) : on_ticks;
      off_q <= off_ticks;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      dur_q   <= '0;
    end else if ((state_d == IDLE) || reload) begin
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) dur_q <= dur_q + DUR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beep_q <= '0;
    end else if (state_d == IDLE) begin
      beep_q <= '0;
    end else if (accept) begin
      beep_q <= (beeps == '0) ? CNT_W'(1) : beeps;
    end else if ((state_q == TONE) && on_expire && !last_beep) begin
      beep_q <= beep_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      sound_q <= 1'b0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      sound_q <= sound_d;
    end
  end

  tone_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .clr        (div_clr),
    .en         (div_en),
    .half_period(h_q),
    .phase      (phase)
  );

  // Both pins are gated by a registered enable so no DC sits on the speaker.
  assign spk_p = phase & sound_q;
  assign spk_n = ~phase & sound_q;

endmodule
